pio_stream_bridge: RTL
======================

# pio_stream_bridge

Parametrised HPS↔FPGA PIO bridge that carries samples and results over plain 16-bit Qsys PIO words, which have no strobe. A toggle handshake carries each word. Inbound samples from the HPS are buffered in a FIFO and presented as a valid/ready stream to the FIR datapath. FIR results are returned through a single holding register with its own toggle. The block sits between the `arm_hps` PIO exports (`pio_hps2fpga_export`, `pio_fpga2hps_export`) and the filter core, all in the `clk_clk` domain.

## Interface
Parameters:
- `PIO_W`, default 16: PIO word width. Bit `PIO_W-1` is the request toggle, bit `PIO_W-2` is the read-ack/result toggle, bits `PIO_W-3:0` are payload.
- `DEPTH`, default 8: inbound FIFO depth. Must be a power of two, ≥2.
- `LVL_W`, default `$clog2(DEPTH)+1`: occupancy width.

Ports:
- `clk_clk`, input, 1: sole clock.
- `reset_reset_n`, input, 1: asynchronous, active-low reset.
- `hps2fpga_i`, input, `PIO_W`: from `pio_hps2fpga_export`. Fields are {req_tog, rd_ack_tog, sample}.
- `fpga2hps_o`, output, `PIO_W`: to `pio_fpga2hps_export`. Fields are {req_ack_tog, res_tog, result}.
- `smp_valid_o`, output, 1: FIFO head valid.
- `smp_ready_i`, input, 1: FIR accepts the head.
- `smp_data_o`, output, `PIO_W-2`: FIFO head (show-ahead).
- `res_valid_i`, input, 1: FIR result valid.
- `res_ready_o`, output, 1: holding register empty.
- `res_data_i`, input, `PIO_W-2`: FIR result.
- `status_o`, output, `LVL_W+2`: {level, full, empty}. See Configuration.

## Operation
- `hps2fpga_i` is registered once into `h_q`. The HPS writes payload and toggles in one atomic word. It must preserve the bit it is not flipping.
- Inbound request:
  - `req_pend = h_q[PIO_W-1] != req_ack_tog`.
  - `push = req_pend && (!full || pop)`.
  - On push: write `h_q[PIO_W-3:0]` at the write pointer and set `req_ack_tog = h_q[PIO_W-1]`.
  - When the FIFO is full with no pop, the request stays pending with no loss. It retries every cycle.
- FIFO:
  - Circular buffer with `$clog2(DEPTH)` pointers that wrap modulo `DEPTH`. Occupancy counter runs 0..DEPTH.
  - `pop = smp_valid_o && smp_ready_i`.
  - Simultaneous push and pop leaves `level` unchanged; both pointers advance.
  - `smp_valid_o = (level != 0)`. `smp_data_o` = mem[rd_ptr].
- Outbound result:
  - The holding register is empty when `res_tog == h_q[PIO_W-2]`. `res_ready_o` = empty.
  - On `res_valid_i && res_ready_o`: load result and flip `res_tog`. The register is then full until the HPS writes rd_ack_tog equal to the new `res_tog`.
- `fpga2hps_o = {req_ack_tog, res_tog, result_q}`. All fields are registered.
- Both directions operate independently and concurrently.
- HPS protocol (normative for driver):
  - To send: write `{~req_ack_tog, rd_ack_tog_current, sample}`, then poll until `fpga2hps[PIO_W-1]` matches.
  - To receive: poll until `fpga2hps[PIO_W-2] != rd_ack_tog`, read the payload, then write the flipped rd_ack_tog.

## Timing
- Reset: all toggles, pointers, level and `result_q` are 0. `fpga2hps_o = 0`, `smp_valid_o = 0`, `res_ready_o = 1` once `h_q` = 0, `status_o = {0,0,1}` when enabled.
- Reset mid-operation discards FIFO contents and any held result. If `hps2fpga_i` has req_tog=1 when reset releases, it is taken as a new request. The driver writes 0 before releasing the filter.
- Req toggle change on `hps2fpga_i` before edge k: captured into `h_q` at edge k, pushed at edge k+1. `req_ack_tog` flips and `smp_valid_o` asserts (if previously empty) after edge k+1. Latency is 2 cycles.
- The pop path is combinational from `smp_ready_i` into push eligibility when full. There is no other combinational input→output path except `res_ready_o` from registers.
- Result accept at edge j: `res_tog`/payload change after edge j. HPS rd_ack captured at edge m makes `res_ready_o` high after edge m.
- Throughput: one push and one pop per cycle.

## Configuration
- `PIO_BRIDGE_STATUS_EN` defined: `status_o = {level, full, empty}`, registered, same cycle as the FIFO state.
- Not defined: `status_o` is tied to 0 and the status logic is not synthesised. FIFO behaviour is unchanged.

## Test plan
- Reset, then one write `hps2fpga=0x8123` → `fpga2hps[15]=1` and `smp_valid_o=1`, `smp_data_o=0x0123`, 2 cycles after capture.
- `smp_ready_i=0`, push 9 toggled samples 0x0001..0x0009 at DEPTH=8 → level=8, full=1, 9th ack withheld. Raise `smp_ready_i` → data pops in order 1..9 and the 9th ack appears.
- Full FIFO with `smp_ready_i=1` and a pending request in the same cycle → push and pop both occur, level stays 8.
- `res_valid_i=1`, `res_data_i=0x2ABC` → `fpga2hps[14]=1`, payload=0x2ABC, `res_ready_o=0`. A second result is held off until the HPS writes bit14=1, then the second result loads.
- Assert `reset_reset_n=0` with level=5 and a result held → next cycle all outputs at reset values. After release with `hps2fpga=0`, no spurious push.
- Build without `PIO_BRIDGE_STATUS_EN` → `status_o` stays 0 through the full/empty scenario above.

Source files
------------

// File: rtl/pio_stream_bridge.sv
// pio_stream_bridge: carries samples and results between strobe-less HPS PIO words and the FIR stream using toggle handshakes.
// Latency: a request toggle is pushed 2 cycles after it appears on hps2fpga_i; an accepted result appears on fpga2hps_o 1 cycle later.
// Backpressure: a full FIFO leaves the request pending with its ack withheld; a held result keeps res_ready_o low until the HPS acks it.
// Optional feature: define PIO_BRIDGE_STATUS_EN to drive status_o = {level, full, empty}; otherwise status_o is tied to 0.
module pio_stream_bridge #(
    parameter int PIO_W = 16,
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [PIO_W-1:0] hps2fpga_i,
    output logic [PIO_W-1:0] fpga2hps_o,
    output logic             smp_valid_o,
    input  logic             smp_ready_i,
    output logic [PIO_W-3:0] smp_data_o,
    input  logic             res_valid_i,
    output logic             res_ready_o,
    input  logic [PIO_W-3:0] res_data_i,
    output logic [LVL_W+1:0] status_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int DAT_W = PIO_W - 2;

    // HPS word register and handshake state
    logic [PIO_W-1:0] h_q;
    logic             req_ack_tog;
    logic             res_tog;
    logic [DAT_W-1:0] result_q;

    // Inbound FIFO storage and bookkeeping
    logic [DAT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;

    logic full;
    logic empty;
    logic req_pend;
    logic push;
    logic pop;
    logic res_take;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign req_pend = (h_q[PIO_W-1] != req_ack_tog);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign pop      = smp_valid_o && smp_ready_i;
    assign push     = req_pend && (!full || pop);

    assign smp_valid_o = !empty;
    assign smp_data_o  = mem[rd_ptr];

    // Holding register is empty once the HPS has echoed the current result toggle.
    assign res_ready_o = (res_tog == h_q[PIO_W-2]);
    assign res_take    = res_valid_i && res_ready_o;

    assign fpga2hps_o = {req_ack_tog, res_tog, result_q};

    // Capture the HPS PIO word once; every decision below uses this copy.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            h_q <= '0;
        end else begin
            h_q <= hps2fpga_i;
        end
    end

    // Inbound handshake and FIFO pointers/occupancy.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            req_ack_tog <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
        end else begin
            if (push) begin
                req_ack_tog <= h_q[PIO_W-1];
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the pointers and level do.
    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr] <= h_q[DAT_W-1:0];
        end
    end

    // Outbound holding register: load a result and flip its toggle to announce it.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            res_tog  <= 1'b0;
            result_q <= '0;
        end else if (res_take) begin
            res_tog  <= ~res_tog;
            result_q <= res_data_i;
        end
    end

`ifdef PIO_BRIDGE_STATUS_EN
    // Status decodes straight from the registered level, so it tracks the FIFO state cycle for cycle.
    assign status_o = {level, full, empty};
`else
    assign status_o = '0;
`endif

endmodule
